// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding for the set-associative cache controller
package cache_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
endpackage

// File: rtl/plru_tree.sv
// plru_tree: combinational tree pseudo-LRU update and victim selection for one set
module plru_tree #(
  parameter int num_ways = 4,
  localparam int s_way = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] bits,
  input  logic [s_way-1:0]    way,
  output logic [num_ways-2:0] new_bits,
  output logic [s_way-1:0]    victim
);
  int n;
  int m;
  always_comb begin
    new_bits = bits;
    victim = '0;
    n = 0;
    m = 0;
    for (int l = 0; l < s_way; l++) begin
      new_bits[n] = ~way[s_way-1-l];
      n = 2 * n + 1 + int'(way[s_way-1-l]);
      victim[s_way-1-l] = bits[m];
      m = 2 * m + 1 + int'(bits[m]);
    end
  end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way write-back write-allocate cache with tree PLRU and memory controller
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_mask   = 2 ** s_offset,
  parameter int s_line   = 8 * s_mask
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [s_line-1:0] mem_wdata,
  input  logic [s_mask-1:0] mem_byte_enable,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int num_sets = 2 ** s_index;
  localparam int s_way = $clog2(num_ways);
  state_t state, state_n;
  logic [s_tag-1:0] req_tag;
  logic [s_index-1:0] req_idx;
  logic [s_line-1:0] req_wdata;
  logic [s_mask-1:0] req_be;
  logic req_wr;
  logic [s_tag-1:0] tag_a [num_sets][num_ways];
  logic [s_line-1:0] data_a [num_sets][num_ways];
  logic [num_ways-1:0] valid_a [num_sets];
  logic [num_ways-1:0] dirty_a [num_sets];
  logic [num_ways-2:0] plru_a [num_sets];
  logic hit, inv;
  logic [s_way-1:0] hit_way, inv_way, lru_way, victim;
  logic [num_ways-2:0] plru_upd;
  logic [s_line-1:0] merged;
  logic unused_offset;
  assign unused_offset = ^mem_address[s_offset-1:0];
  always_comb begin
    hit = 1'b0;
    inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid_a[req_idx][w] && tag_a[req_idx][w] == req_tag) begin
        hit = 1'b1;
        hit_way = s_way'(w);
      end
      if (!valid_a[req_idx][w]) begin
        inv = 1'b1;
        inv_way = s_way'(w);
      end
    end
  end
  assign victim = inv ? inv_way : lru_way;
  plru_tree #(.num_ways(num_ways)) u_plru (
    .bits(plru_a[req_idx]),
    .way(hit_way),
    .new_bits(plru_upd),
    .victim(lru_way)
  );
  for (genvar b = 0; b < s_mask; b++) begin : g_merge
    assign merged[8*b+:8] = req_be[b] ? req_wdata[8*b+:8] : data_a[req_idx][hit_way][8*b+:8];
  end
  assign mem_rdata = data_a[req_idx][hit_way];
  assign pmem_wdata = data_a[req_idx][victim];
  always_comb begin
    state_n = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = {req_tag, req_idx, {s_offset{1'b0}}};
    case (state)
      IDLE: state_n = (mem_read || mem_write) ? COMPARE : IDLE;
      COMPARE: begin
        mem_resp = hit && !rst;
        state_n = hit ? IDLE : (valid_a[req_idx][victim] && dirty_a[req_idx][victim]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tag_a[req_idx][victim], req_idx, {s_offset{1'b0}}};
        state_n = pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        pmem_read = 1'b1;
        state_n = pmem_resp ? COMPARE : FILL;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int s = 0; s < num_sets; s++) begin
        valid_a[s] <= '0;
        dirty_a[s] <= '0;
        plru_a[s] <= '0;
      end
    end else begin
      state <= state_n;
      if (state == COMPARE && hit) begin
        plru_a[req_idx] <= plru_upd;
        if (req_wr) dirty_a[req_idx][hit_way] <= 1'b1;
      end
      if (state == FILL && pmem_resp) begin
        valid_a[req_idx][victim] <= 1'b1;
        dirty_a[req_idx][victim] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && (mem_read || mem_write)) begin
      req_tag <= mem_address[31-:s_tag];
      req_idx <= mem_address[s_offset+:s_index];
      req_wdata <= mem_wdata;
      req_be <= mem_byte_enable;
      req_wr <= mem_write;
    end
    if (!rst && state == COMPARE && hit && req_wr) data_a[req_idx][hit_way] <= merged;
    if (!rst && state == FILL && pmem_resp) begin
      data_a[req_idx][victim] <= pmem_rdata;
      tag_a[req_idx][victim] <= req_tag;
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: table-driven directed checks of hits, misses, eviction, reset and stray responses
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem_address = '0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic [255:0] mem_wdata = '0;
  logic [31:0] mem_byte_enable = '0;
  logic [255:0] mem_rdata;
  logic mem_resp;
  logic [31:0] pmem_address;
  logic pmem_read;
  logic pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic pmem_resp = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  set_assoc_cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [31:0] be;
    logic [255:0] wdata;
    logic [255:0] fill;
    logic exp_wb;
    logic [31:0] wb_addr;
    logic [255:0] wb_data;
    logic exp_fill;
    logic chk_rd;
    logic [255:0] rdata;
  } vec_t;
  localparam logic [255:0] l_a = {32{8'hA5}};
  localparam logic [255:0] l_w1 = {{28{8'h11}}, 32'hDEADBEEF};
  localparam logic [255:0] l_m = {l_a[255:32], 32'hDEADBEEF};
  localparam logic [255:0] l_b = {32{8'h22}};
  localparam logic [255:0] l_c = {32{8'h33}};
  localparam logic [255:0] l_d = {32{8'h44}};
  localparam logic [255:0] l_e = {32{8'h55}};
  localparam logic [255:0] l_f = {32{8'h66}};
  localparam logic [255:0] l_g = {32{8'h77}};
  localparam logic [255:0] l_h = {32{8'h88}};
  localparam logic [255:0] l_i = {32{8'h99}};
  localparam logic [255:0] l_j = {32{8'hAA}};
  localparam logic [255:0] l_k = {32{8'hBB}};
  vec_t vt [16];
  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] be,
                              input logic [255:0] wd, input logic [255:0] fl, input logic xwb,
                              input logic [31:0] wa, input logic [255:0] wdat, input logic xf,
                              input logic crd, input logic [255:0] rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.be = be; v.wdata = wd; v.fill = fl;
    v.exp_wb = xwb; v.wb_addr = wa; v.wb_data = wdat; v.exp_fill = xf; v.chk_rd = crd; v.rdata = rdat;
    return v;
  endfunction
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int i);
    vec_t v;
    logic wb_seen, fill_seen, done;
    logic [31:0] wba, fa;
    logic [255:0] wbd, rd;
    int cnt, resp_at, lat;
    v = vt[i];
    wb_seen = 0; fill_seen = 0; done = 0; wba = '0; fa = '0; wbd = '0; rd = '0;
    cnt = 0; resp_at = -1; lat = -1;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; mem_address = v.addr; mem_byte_enable = v.be; mem_wdata = v.wdata;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (pmem_resp) pmem_resp = 0;
      else if (pmem_write) begin
        wb_seen = 1; wba = pmem_address; wbd = pmem_wdata; cnt++;
        if (cnt == 3) begin pmem_resp = 1; cnt = 0; end
      end else if (pmem_read) begin
        fill_seen = 1; fa = pmem_address; cnt++;
        if (cnt == 3) begin pmem_rdata = v.fill; pmem_resp = 1; resp_at = c; cnt = 0; end
      end
      if (mem_resp) begin
        done = 1; lat = c; rd = mem_rdata; mem_read = 0; mem_write = 0;
      end
    end
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    check($sformatf("v%0d_done", i), 256'(done), 256'(1));
    check($sformatf("v%0d_wb_seen", i), 256'(wb_seen), 256'(v.exp_wb));
    if (v.exp_wb) begin
      check($sformatf("v%0d_wb_addr", i), 256'(wba), 256'(v.wb_addr));
      check($sformatf("v%0d_wb_data", i), wbd, v.wb_data);
    end
    check($sformatf("v%0d_fill_seen", i), 256'(fill_seen), 256'(v.exp_fill));
    if (v.exp_fill) begin
      check($sformatf("v%0d_fill_addr", i), 256'(fa), 256'(v.addr));
      check($sformatf("v%0d_miss_lat", i), 256'(lat), 256'(resp_at + 1));
    end else check($sformatf("v%0d_hit_lat", i), 256'(lat), 256'(1));
    if (v.chk_rd) check($sformatf("v%0d_rdata", i), rd, v.rdata);
    @(negedge clk);
    check($sformatf("v%0d_resp_pulse", i), 256'(mem_resp), 256'(0));
  endtask
  initial begin
    vt[0]  = mk(1, 0, 32'h1040, '0, '0, l_a, 0, '0, '0, 1, 1, l_a);
    vt[1]  = mk(0, 1, 32'h1040, 32'h0000_000F, l_w1, '0, 0, '0, '0, 0, 0, '0);
    vt[2]  = mk(1, 0, 32'h1040, '0, '0, '0, 0, '0, '0, 0, 1, l_m);
    vt[3]  = mk(1, 0, 32'h2040, '0, '0, l_b, 0, '0, '0, 1, 1, l_b);
    vt[4]  = mk(1, 0, 32'h3040, '0, '0, l_c, 0, '0, '0, 1, 1, l_c);
    vt[5]  = mk(1, 0, 32'h4040, '0, '0, l_d, 0, '0, '0, 1, 1, l_d);
    vt[6]  = mk(1, 0, 32'h5040, '0, '0, l_e, 1, 32'h1040, l_m, 1, 1, l_e);
    vt[7]  = mk(1, 0, 32'h2040, '0, '0, '0, 0, '0, '0, 0, 1, l_b);
    vt[8]  = mk(1, 0, 32'h5040, '0, '0, l_f, 0, '0, '0, 1, 1, l_f);
    vt[9]  = mk(1, 1, 32'h5040, 32'hFFFF_FFFF, l_g, '0, 0, '0, '0, 0, 0, '0);
    vt[10] = mk(1, 0, 32'h5040, '0, '0, '0, 0, '0, '0, 0, 1, l_g);
    vt[11] = mk(1, 0, 32'h6040, '0, '0, l_h, 0, '0, '0, 1, 1, l_h);
    vt[12] = mk(1, 0, 32'h7040, '0, '0, l_i, 0, '0, '0, 1, 1, l_i);
    vt[13] = mk(1, 0, 32'h8040, '0, '0, l_j, 0, '0, '0, 1, 1, l_j);
    vt[14] = mk(1, 0, 32'h9040, '0, '0, l_k, 1, 32'h5040, l_g, 1, 1, l_k);
    vt[15] = mk(1, 0, 32'h9040, '0, '0, '0, 0, '0, '0, 0, 1, l_k);
    repeat (2) @(negedge clk);
    check("reset_mem_resp", 256'(mem_resp), 256'(0));
    check("reset_pmem_read", 256'(pmem_read), 256'(0));
    check("reset_pmem_write", 256'(pmem_write), 256'(0));
    rst = 0;
    for (int i = 0; i <= 7; i++) run_vec(i);
    mem_read = 1; mem_address = 32'h6040;
    for (int c = 0; c < 20 && !pmem_read; c++) @(negedge clk);
    check("midfill_pmem_read_seen", 256'(pmem_read), 256'(1));
    rst = 1; mem_read = 0;
    @(negedge clk);
    rst = 0;
    check("midfill_pmem_read_dropped", 256'(pmem_read), 256'(0));
    check("midfill_pmem_write_low", 256'(pmem_write), 256'(0));
    check("midfill_no_resp", 256'(mem_resp), 256'(0));
    repeat (3) begin
      @(negedge clk);
      check("midfill_idle_quiet", 256'({mem_resp, pmem_read, pmem_write}), 256'(0));
    end
    for (int i = 8; i <= 14; i++) run_vec(i);
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0;
    repeat (3) begin
      check("stray_resp_quiet", 256'({mem_resp, pmem_read, pmem_write}), 256'(0));
      @(negedge clk);
    end
    run_vec(15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
